// File: rtl/sha_nonce_sequencer.sv
// ---------------------------------------------------------------------------
// sha_nonce_sequencer
//
// Sequencing controller for a double-SHA-256 mining datapath. It walks an
// inclusive nonce range. For each nonce it drives the accumulator phase code,
// the midstate-reuse flag and the compression round index. At the end of each
// nonce it compares the most-significant final hash word against a target.
// A search ends on a hit, when the range is used up, or on an abort request.
//
// The first nonce of a search runs the full schedule:
//   INIT, CHUNK1, ACC1, CHUNK2, ACC2, HASH2, ACC3, CHECK
// Later nonces reuse the chunk-1 midstate, so they restart at CHUNK2.
//
// Ports
//   clk_i          clock; all logic is on the rising edge
//   rst_ni         synchronous active-low reset
//   start_i        one-cycle pulse that starts a search (only taken in IDLE)
//   stop_i         abort; sampled every cycle
//   nonce_start_i  first nonce, captured on an accepted start
//   nonce_end_i    last nonce (inclusive), captured on an accepted start
//   target_i       hit threshold, captured on an accepted start
//   hash_word_i    most-significant final hash word, valid in CHECK
//   block_o        phase code to the accumulators (0..3)
//   nonce_sig_o    0 on the first nonce of a search, 1 on later nonces
//   round_o        round index 0..ROUNDS-1; 0 whenever round_en_o is low
//   round_en_o     high on every compression-round cycle
//   nonce_o        nonce currently being hashed
//   busy_o         high while a search is in progress
//   found_o        sticky hit flag
//   found_nonce_o  nonce that produced the hit
//   exhausted_o    sticky "range finished without a hit" flag
// ---------------------------------------------------------------------------
module sha_nonce_sequencer #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] nonce_start_i,
  input  logic [31:0] nonce_end_i,
  input  logic [31:0] target_i,
  input  logic [31:0] hash_word_i,
  output logic [1:0]  block_o,
  output logic        nonce_sig_o,
  output logic [5:0]  round_o,
  output logic        round_en_o,
  output logic [31:0] nonce_o,
  output logic        busy_o,
  output logic        found_o,
  output logic [31:0] found_nonce_o,
  output logic        exhausted_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_CHUNK1,
    S_ACC1,
    S_CHUNK2,
    S_ACC2,
    S_HASH2,
    S_ACC3,
    S_CHECK
  } state_e;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_e      state_q;
  logic [1:0]  block_q;
  logic        nonceSig_q;
  logic [5:0]  round_q;
  logic        roundEn_q;
  logic [31:0] nonce_q;
  logic        busy_q;
  logic        found_q;
  logic [31:0] foundNonce_q;
  logic        exhausted_q;
  logic [31:0] nonceEnd_q;
  logic [31:0] target_q;

  logic        roundLast_d;
  logic        hit_d;
  logic        lastNonce_d;
  logic        abort_d;
  logic        accept_d;
  logic [31:0] nonceNext_d;
  logic [5:0]  roundNext_d;

  // Decision terms shared by the state machine. The nonce increment wraps
  // naturally at 2^32, which is what makes a wrapped range work.
  always_comb begin
    roundLast_d = (round_q == LAST_ROUND);
    hit_d       = (hash_word_i <= target_q);
    lastNonce_d = (nonce_q == nonceEnd_q);
    abort_d     = stop_i && (state_q != S_IDLE);
    accept_d    = start_i && !stop_i && (state_q == S_IDLE);
    nonceNext_d = nonce_q + 32'd1;
    roundNext_d = round_q + 6'd1;
  end

  // Single registered state machine. Each transition also loads the output
  // registers for the state being entered, so every output lines up with
  // state_q in the same cycle. Reset and stop take priority over all else.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      block_q      <= 2'd0;
      nonceSig_q   <= 1'b0;
      round_q      <= 6'd0;
      roundEn_q    <= 1'b0;
      nonce_q      <= 32'd0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      foundNonce_q <= 32'd0;
      exhausted_q  <= 1'b0;
      nonceEnd_q   <= 32'd0;
      target_q     <= 32'd0;
    end else if (abort_d) begin
      // The flags were cleared when the search began, so an abort leaves
      // them at 0 and drops any CHECK result from this cycle.
      state_q    <= S_IDLE;
      block_q    <= 2'd0;
      nonceSig_q <= 1'b0;
      round_q    <= 6'd0;
      roundEn_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            state_q     <= S_INIT;
            nonce_q     <= nonce_start_i;
            nonceEnd_q  <= nonce_end_i;
            target_q    <= target_i;
            nonceSig_q  <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            busy_q      <= 1'b1;
            block_q     <= 2'd0;
            round_q     <= 6'd0;
            roundEn_q   <= 1'b0;
          end
        end

        S_INIT: begin
          state_q   <= S_CHUNK1;
          block_q   <= 2'd0;
          round_q   <= 6'd0;
          roundEn_q <= 1'b1;
        end

        S_CHUNK1: begin
          if (roundLast_d) begin
            state_q   <= S_ACC1;
            block_q   <= 2'd1;
            round_q   <= 6'd0;
            roundEn_q <= 1'b0;
          end else begin
            round_q <= roundNext_d;
          end
        end

        S_ACC1: begin
          state_q   <= S_CHUNK2;
          block_q   <= 2'd1;
          round_q   <= 6'd0;
          roundEn_q <= 1'b1;
        end

        S_CHUNK2: begin
          if (roundLast_d) begin
            state_q   <= S_ACC2;
            block_q   <= 2'd2;
            round_q   <= 6'd0;
            roundEn_q <= 1'b0;
          end else begin
            round_q <= roundNext_d;
          end
        end

        S_ACC2: begin
          state_q   <= S_HASH2;
          block_q   <= 2'd2;
          round_q   <= 6'd0;
          roundEn_q <= 1'b1;
        end

        S_HASH2: begin
          if (roundLast_d) begin
            state_q   <= S_ACC3;
            block_q   <= 2'd3;
            round_q   <= 6'd0;
            roundEn_q <= 1'b0;
          end else begin
            round_q <= roundNext_d;
          end
        end

        S_ACC3: begin
          state_q <= S_CHECK;
          block_q <= 2'd3;
        end

        S_CHECK: begin
          if (hit_d) begin
            state_q      <= S_IDLE;
            found_q      <= 1'b1;
            foundNonce_q <= nonce_q;
            busy_q       <= 1'b0;
            block_q      <= 2'd0;
            nonceSig_q   <= 1'b0;
          end else if (lastNonce_d) begin
            state_q     <= S_IDLE;
            exhausted_q <= 1'b1;
            busy_q      <= 1'b0;
            block_q     <= 2'd0;
            nonceSig_q  <= 1'b0;
          end else begin
            // The chunk-1 midstate is reused, so go straight to CHUNK2.
            state_q    <= S_CHUNK2;
            nonce_q    <= nonceNext_d;
            nonceSig_q <= 1'b1;
            block_q    <= 2'd1;
            round_q    <= 6'd0;
            roundEn_q  <= 1'b1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          block_q    <= 2'd0;
          nonceSig_q <= 1'b0;
          round_q    <= 6'd0;
          roundEn_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign block_o       = block_q;
  assign nonce_sig_o   = nonceSig_q;
  assign round_o       = round_q;
  assign round_en_o    = roundEn_q;
  assign nonce_o       = nonce_q;
  assign busy_o        = busy_q;
  assign found_o       = found_q;
  assign found_nonce_o = foundNonce_q;
  assign exhausted_o   = exhausted_q;

endmodule
